// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - DDR4 command/bank-state types and default timing values
//
// Shared by ddr_bank_fsm and ddr_bank_timer.
//   ddr_cmd_e    : 3-bit command encoding driven on cmd_type
//   bank_state_e : per-bank lifecycle IDLE -> OPENING -> ACTIVE -> CLOSING
//   DEF_*        : default timing parameters, in clocks
//   load_val     : counter load value for a constraint T (T-1, floored at 0)
package ddr_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        ACT  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        PRE  = 3'd4,
        PREA = 3'd5,
        REF  = 3'd6
    } ddr_cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        OPENING,
        ACTIVE,
        CLOSING
    } bank_state_e;

    localparam int DEF_NUM_BANKS    = 16;
    localparam int DEF_BANKS_PER_BG = 4;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_REF_W        = 16;
    localparam int DEF_T_RCD        = 14;
    localparam int DEF_T_RP         = 14;
    localparam int DEF_T_RAS        = 32;
    localparam int DEF_T_CCD_S      = 4;
    localparam int DEF_T_CCD_L      = 6;
    localparam int DEF_T_REFI       = 6240;
    localparam int DEF_T_RFC        = 280;
    localparam int DEF_REF_ALMOST   = 64;

    // A constraint of T clocks is tracked by loading T-1 and counting to 0,
    // so the dependent ready rises exactly T cycles after the command.
    function automatic int load_val(input int t);
        return (t > 0) ? t - 1 : 0;
    endfunction

endpackage

// File: rtl/ddr_bank_fsm.sv
// rtl/ddr_bank_fsm.sv - single-bank state machine with tRCD/tRP/tRAS/RD-WR-to-PRE counters
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   busy                     refresh (tRFC) in progress, blocks ACT and CAS
//   ccd_ok                   tCCD satisfied for this bank's group
//   act_go/rd_go/wr_go       accepted ACT/RD/WR targeting this bank
//   pre_go                   accepted PRE to this bank or PREA
//   cfg_rd_pre, cfg_wr_pre   RD->PRE / WR->PRE distances, sampled on accept
//   act_rdy/cas_rdy/pre_rdy  per-bank command legality
//   bank_open, bank_idle     state == ACTIVE / state == IDLE
module ddr_bank_fsm
    import ddr_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int T_RCD = DEF_T_RCD,
    parameter int T_RP  = DEF_T_RP,
    parameter int T_RAS = DEF_T_RAS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busy,
    input  logic             ccd_ok,
    input  logic             act_go,
    input  logic             rd_go,
    input  logic             wr_go,
    input  logic             pre_go,
    input  logic [CNT_W-1:0] cfg_rd_pre,
    input  logic [CNT_W-1:0] cfg_wr_pre,
    output logic             act_rdy,
    output logic             cas_rdy,
    output logic             pre_rdy,
    output logic             bank_open,
    output logic             bank_idle
);

    localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(load_val(T_RCD));
    localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(load_val(T_RP));
    localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(load_val(T_RAS));

    bank_state_e      state, state_next;
    logic [CNT_W-1:0] rcd, rp, ras, r2p;

    function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] max2(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // OPENING/CLOSING leave on the edge where their counter reaches 0, so the
    // state and the counter expire together; a zero load skips the state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (act_go) state_next = (RCD_LD == '0) ? ACTIVE : OPENING;
            OPENING: if (rcd <= CNT_W'(1)) state_next = ACTIVE;
            ACTIVE:  if (pre_go) state_next = (RP_LD == '0) ? IDLE : CLOSING;
            CLOSING: if (rp <= CNT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rcd   <= '0;
            rp    <= '0;
            ras   <= '0;
            r2p   <= '0;
        end else begin
            state <= state_next;
            rcd   <= (state == IDLE && act_go) ? RCD_LD : dec(rcd);
            ras   <= (state == IDLE && act_go) ? RAS_LD : dec(ras);
            rp    <= (state == ACTIVE && pre_go) ? RP_LD : dec(rp);
            // Keep the later of the pending and the new PRE deadline.
            if (state == ACTIVE && rd_go)
                r2p <= max2(dec(r2p), dec(cfg_rd_pre));
            else if (state == ACTIVE && wr_go)
                r2p <= max2(dec(r2p), dec(cfg_wr_pre));
            else
                r2p <= dec(r2p);
        end
    end

    assign bank_idle = (state == IDLE);
    assign bank_open = (state == ACTIVE);
    assign act_rdy   = bank_idle && !busy;
    assign cas_rdy   = bank_open && ccd_ok && !busy;
    assign pre_rdy   = bank_open && (ras == '0) && (r2p == '0);

endmodule

// File: rtl/ddr_bank_timer.sv
// rtl/ddr_bank_timer.sv - per-bank DDR4 timing tracker and command-legality checker
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   cmd_valid, cmd_type, cmd_bank issued command (bank ignored for PREA/REF)
//   cfg_rd_pre, cfg_wr_pre        RD->PRE / WR->PRE distances
//   act_rdy, cas_rdy, pre_rdy     per-bank legality vectors
//   bank_open                     per-bank ACTIVE indication
//   prea_rdy, refresh_rdy         global legality
//   refresh_almost, refresh_req   refresh interval status
//   refresh_done, busy            end-of-tRFC pulse, tRFC in progress
//   illegal_cmd                   pulse: previous command issued while not ready
module ddr_bank_timer
    import ddr_pkg::*;
#(
    parameter int NUM_BANKS    = DEF_NUM_BANKS,
    parameter int BANKS_PER_BG = DEF_BANKS_PER_BG,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int REF_W        = DEF_REF_W,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_RAS        = DEF_T_RAS,
    parameter int T_CCD_S      = DEF_T_CCD_S,
    parameter int T_CCD_L      = DEF_T_CCD_L,
    parameter int T_REFI       = DEF_T_REFI,
    parameter int T_RFC        = DEF_T_RFC,
    parameter int REF_ALMOST   = DEF_REF_ALMOST
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    input  logic [2:0]                   cmd_type,
    input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
    input  logic [CNT_W-1:0]             cfg_rd_pre,
    input  logic [CNT_W-1:0]             cfg_wr_pre,
    output logic [NUM_BANKS-1:0]         act_rdy,
    output logic [NUM_BANKS-1:0]         cas_rdy,
    output logic [NUM_BANKS-1:0]         pre_rdy,
    output logic [NUM_BANKS-1:0]         bank_open,
    output logic                         prea_rdy,
    output logic                         refresh_rdy,
    output logic                         refresh_almost,
    output logic                         refresh_req,
    output logic                         refresh_done,
    output logic                         busy,
    output logic                         illegal_cmd
);

    localparam int               BANK_W   = $clog2(NUM_BANKS);
    localparam int               BG_SHIFT = $clog2(BANKS_PER_BG);
    localparam logic [CNT_W-1:0] CCD_LD   = CNT_W'(load_val(T_CCD_L));
    localparam logic [REF_W-1:0] RFC_LD   = REF_W'(load_val(T_RFC));
    localparam logic [REF_W-1:0] REFI_LD  = REF_W'(T_REFI);

    ddr_cmd_e              cmd;
    logic                  legal, accept, cas_accept, ref_accept, ccd_s_ok;
    logic [NUM_BANKS-1:0]  bank_idle, ccd_ok, act_go, rd_go, wr_go, pre_go;
    logic [CNT_W-1:0]      ccd_cnt;
    logic [BANK_W-1:0]     last_grp, cmd_grp;
    logic [REF_W-1:0]      ref_cnt, ref_next, rfc_cnt;

    assign cmd     = ddr_cmd_e'(cmd_type);
    assign cmd_grp = cmd_bank >> BG_SHIFT;

    always_comb begin
        legal = 1'b1;
        case (cmd)
            ACT:     legal = act_rdy[cmd_bank];
            RD, WR:  legal = cas_rdy[cmd_bank];
            PRE:     legal = pre_rdy[cmd_bank];
            PREA:    legal = prea_rdy;
            REF:     legal = refresh_rdy;
            default: legal = 1'b1;
        endcase
    end

    assign accept     = cmd_valid && legal;
    assign cas_accept = accept && (cmd == RD || cmd == WR);
    assign ref_accept = accept && (cmd == REF);

    // The counter always times T_CCD_L; other groups only need T_CCD_S of it
    // to have elapsed, i.e. elapsed = T_CCD_L - ccd_cnt >= T_CCD_S.
    assign ccd_s_ok = (int'(ccd_cnt) + T_CCD_S) <= T_CCD_L;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic hit;
        assign hit       = (cmd_bank == BANK_W'(b));
        assign ccd_ok[b] = (BANK_W'(b >> BG_SHIFT) == last_grp) ? (ccd_cnt == '0) : ccd_s_ok;
        assign act_go[b] = accept && (cmd == ACT) && hit;
        assign rd_go[b]  = accept && (cmd == RD) && hit;
        assign wr_go[b]  = accept && (cmd == WR) && hit;
        assign pre_go[b] = accept && (((cmd == PRE) && hit) || (cmd == PREA));

        ddr_bank_fsm #(
            .CNT_W (CNT_W),
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS)
        ) u_bank (
            .clk        (clk),
            .rst        (reset),
            .busy       (busy),
            .ccd_ok     (ccd_ok[b]),
            .act_go     (act_go[b]),
            .rd_go      (rd_go[b]),
            .wr_go      (wr_go[b]),
            .pre_go     (pre_go[b]),
            .cfg_rd_pre (cfg_rd_pre),
            .cfg_wr_pre (cfg_wr_pre),
            .act_rdy    (act_rdy[b]),
            .cas_rdy    (cas_rdy[b]),
            .pre_rdy    (pre_rdy[b]),
            .bank_open  (bank_open[b]),
            .bank_idle  (bank_idle[b])
        );
    end

    always_comb begin
        if (ref_accept)
            ref_next = REFI_LD;
        else if (ref_cnt == '0)
            ref_next = ref_cnt;
        else
            ref_next = ref_cnt - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ccd_cnt      <= '0;
            last_grp     <= '0;
            ref_cnt      <= REFI_LD;
            refresh_req  <= 1'b0;
            rfc_cnt      <= '0;
            refresh_done <= 1'b0;
            illegal_cmd  <= 1'b0;
        end else begin
            if (cas_accept) begin
                ccd_cnt  <= CCD_LD;
                last_grp <= cmd_grp;
            end else if (ccd_cnt != '0) begin
                ccd_cnt  <= ccd_cnt - 1'b1;
            end
            ref_cnt     <= ref_next;
            refresh_req <= !ref_accept && (refresh_req || ref_next == '0);
            if (ref_accept)
                rfc_cnt <= RFC_LD;
            else if (rfc_cnt != '0)
                rfc_cnt <= rfc_cnt - 1'b1;
            // Pulse in the first cycle busy is low again after a REF.
            refresh_done <= ref_accept ? (RFC_LD == '0) : (rfc_cnt == REF_W'(1));
            illegal_cmd  <= cmd_valid && !legal;
        end
    end

    assign busy           = (rfc_cnt != '0);
    assign refresh_almost = (ref_cnt <= REF_W'(REF_ALMOST));
    assign prea_rdy       = &(bank_idle | pre_rdy);
    assign refresh_rdy    = (&bank_idle) && !busy;

endmodule

// File: tb/tb_ddr_bank_timer.sv
// tb/tb_ddr_bank_timer.sv - scoreboard bench for ddr_bank_timer
module tb_ddr_bank_timer;
    import ddr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [3:0]  cmd_bank;
    logic [7:0]  cfg_rd_pre, cfg_wr_pre;
    logic [15:0] act_rdy, cas_rdy, pre_rdy, bank_open;
    logic        prea_rdy, refresh_rdy, refresh_almost, refresh_req;
    logic        refresh_done, busy, illegal_cmd;

    ddr_bank_timer dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_type       (cmd_type),
        .cmd_bank       (cmd_bank),
        .cfg_rd_pre     (cfg_rd_pre),
        .cfg_wr_pre     (cfg_wr_pre),
        .act_rdy        (act_rdy),
        .cas_rdy        (cas_rdy),
        .pre_rdy        (pre_rdy),
        .bank_open      (bank_open),
        .prea_rdy       (prea_rdy),
        .refresh_rdy    (refresh_rdy),
        .refresh_almost (refresh_almost),
        .refresh_req    (refresh_req),
        .refresh_done   (refresh_done),
        .busy           (busy),
        .illegal_cmd    (illegal_cmd)
    );

    always #5 clk = ~clk;

    typedef enum int {S_ACT, S_CAS, S_PRE, S_OPEN, S_PREA, S_REFR,
                      S_ALM, S_REQ, S_DONE, S_BUSY, S_ILL} sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        int          bank;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    function automatic logic [15:0] actual(input sig_e s);
        case (s)
            S_ACT:   return act_rdy;
            S_CAS:   return cas_rdy;
            S_PRE:   return pre_rdy;
            S_OPEN:  return bank_open;
            S_PREA:  return {15'b0, prea_rdy};
            S_REFR:  return {15'b0, refresh_rdy};
            S_ALM:   return {15'b0, refresh_almost};
            S_REQ:   return {15'b0, refresh_req};
            S_DONE:  return {15'b0, refresh_done};
            S_BUSY:  return {15'b0, busy};
            default: return {15'b0, illegal_cmd};
        endcase
    endfunction

    task automatic expect_at(input int c, input sig_e s, input int b, input logic [15:0] v);
        exp_t e;
        e.cyc = c; e.sig = s; e.bank = b; e.val = v;
        sb.push_back(e);
    endtask

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        logic [15:0] got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                got = actual(sb[i].sig);
                if (sb[i].bank >= 0) got = {15'b0, got[sb[i].bank]};
                checks++;
                if (got !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s[%0d] cycle %0d: got %h expected %h",
                             sb[i].sig.name(), sb[i].bank, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc && !reset) begin
                checks++;
                errors++;
                $display("FAIL %s[%0d] cycle %0d never sampled", sb[i].sig.name(), sb[i].bank, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    task automatic issue(input int c, input ddr_cmd_e t, input int b);
        if (cyc > c) begin
            checks++;
            errors++;
            $display("FAIL schedule %s at cycle %0d: already at cycle %0d", t.name(), c, cyc);
        end
        while (cyc < c) begin @(posedge clk); #1; end
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_bank  = 4'(b);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_type  = NOP;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_type = NOP; cmd_bank = '0;
        cfg_rd_pre = 8'd8; cfg_wr_pre = 8'd20;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        expect_at(0, S_ACT, -1, 16'hFFFF);  expect_at(0, S_CAS, -1, 16'h0000);
        expect_at(0, S_PRE, -1, 16'h0000);  expect_at(0, S_OPEN, -1, 16'h0000);
        expect_at(0, S_PREA, -1, 16'd1);    expect_at(0, S_REFR, -1, 16'd1);
        expect_at(0, S_BUSY, -1, 16'd0);    expect_at(0, S_REQ, -1, 16'd0);
        expect_at(0, S_DONE, -1, 16'd0);    expect_at(0, S_ILL, -1, 16'd0);
        expect_at(0, S_ALM, -1, 16'd0);

        // ACT bank 3 at 10: tRCD and tRAS
        expect_at(11, S_CAS, 3, 16'd0);  expect_at(23, S_CAS, 3, 16'd0);
        expect_at(24, S_CAS, 3, 16'd1);  expect_at(23, S_OPEN, 3, 16'd0);
        expect_at(24, S_OPEN, 3, 16'd1); expect_at(11, S_ACT, 3, 16'd0);
        expect_at(41, S_PRE, 3, 16'd0);  expect_at(42, S_PRE, 3, 16'd1);
        expect_at(11, S_REFR, -1, 16'd0); expect_at(11, S_PREA, -1, 16'd0);
        // ACT bank 5 at 11, illegal RD at 15
        expect_at(15, S_ILL, -1, 16'd0); expect_at(16, S_ILL, -1, 16'd1);
        expect_at(17, S_ILL, -1, 16'd0); expect_at(16, S_OPEN, 5, 16'd0);
        expect_at(24, S_CAS, 5, 16'd0);  expect_at(25, S_CAS, 5, 16'd1);
        issue(10, ACT, 3);
        issue(11, ACT, 5);
        issue(12, ACT, 0);
        issue(13, ACT, 1);
        issue(14, ACT, 4);
        issue(15, RD, 5);
        issue(16, ACT, 2);

        // RD bank 0 at 50: tCCD_L in group 0, tCCD_S for group 1, RD->PRE
        expect_at(51, S_CAS, 3, 16'd0);
        expect_at(53, S_CAS, 4, 16'd0);  expect_at(54, S_CAS, 4, 16'd1);
        expect_at(55, S_CAS, 1, 16'd0);  expect_at(56, S_CAS, 1, 16'd1);
        expect_at(55, S_CAS, 0, 16'd0);  expect_at(56, S_CAS, 0, 16'd1);
        expect_at(53, S_ILL, -1, 16'd1);
        expect_at(57, S_PRE, 0, 16'd0);  expect_at(58, S_PRE, 0, 16'd1);
        expect_at(61, S_ILL, -1, 16'd1); expect_at(61, S_OPEN, 3, 16'd1);
        issue(50, RD, 0);
        issue(52, RD, 1);
        issue(60, ACT, 3);

        // RD->PRE keeps the later deadline
        expect_at(99, S_PRE, 4, 16'd0);  expect_at(100, S_PRE, 4, 16'd1);
        cfg_rd_pre = 8'd30;
        issue(70, RD, 4);
        cfg_rd_pre = 8'd4;
        issue(80, RD, 4);

        // WR bank 2 at 100 with write recovery 20, PRE at 120
        expect_at(99, S_PRE, 2, 16'd1);  expect_at(101, S_PRE, 2, 16'd0);
        expect_at(119, S_PRE, 2, 16'd0); expect_at(120, S_PRE, 2, 16'd1);
        expect_at(111, S_ILL, -1, 16'd1);
        expect_at(121, S_OPEN, 2, 16'd0);
        expect_at(133, S_ACT, 2, 16'd0); expect_at(134, S_ACT, 2, 16'd1);
        expect_at(133, S_PREA, -1, 16'd0); expect_at(134, S_PREA, -1, 16'd1);
        issue(100, WR, 2);
        issue(110, PRE, 2);
        issue(120, PRE, 2);

        // REF with banks open is illegal; PREA closes all
        expect_at(140, S_REFR, -1, 16'd0); expect_at(141, S_ILL, -1, 16'd1);
        expect_at(151, S_OPEN, -1, 16'h0000);
        expect_at(163, S_ACT, 0, 16'd0);  expect_at(164, S_ACT, -1, 16'hFFFF);
        expect_at(163, S_REFR, -1, 16'd0); expect_at(164, S_REFR, -1, 16'd1);
        issue(140, REF, 0);
        issue(150, PREA, 0);

        // Refresh interval and tRFC
        expect_at(6175, S_ALM, -1, 16'd0); expect_at(6176, S_ALM, -1, 16'd1);
        expect_at(6239, S_REQ, -1, 16'd0); expect_at(6240, S_REQ, -1, 16'd1);
        expect_at(6249, S_REQ, -1, 16'd1); expect_at(6251, S_REQ, -1, 16'd0);
        expect_at(6251, S_BUSY, -1, 16'd1); expect_at(6251, S_ACT, -1, 16'h0000);
        expect_at(6251, S_ALM, -1, 16'd0); expect_at(6300, S_REFR, -1, 16'd0);
        expect_at(6301, S_ILL, -1, 16'd1);
        expect_at(6529, S_BUSY, -1, 16'd1); expect_at(6529, S_ACT, -1, 16'h0000);
        expect_at(6529, S_DONE, -1, 16'd0); expect_at(6530, S_DONE, -1, 16'd1);
        expect_at(6530, S_BUSY, -1, 16'd0); expect_at(6530, S_ACT, -1, 16'hFFFF);
        expect_at(6531, S_DONE, -1, 16'd0);
        issue(6250, REF, 0);
        issue(6300, REF, 0);

        // Asynchronous reset mid-tRFC
        expect_at(6700, S_BUSY, -1, 16'd1);
        issue(6600, REF, 0);
        wait_cyc(6701);
        expect_at(6701, S_BUSY, -1, 16'd0); expect_at(6701, S_ACT, -1, 16'hFFFF);
        expect_at(6701, S_REFR, -1, 16'd1); expect_at(6701, S_REQ, -1, 16'd0);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        expect_at(1, S_BUSY, -1, 16'd0);    expect_at(1, S_ACT, -1, 16'hFFFF);
        expect_at(6175, S_ALM, -1, 16'd0); expect_at(6176, S_ALM, -1, 16'd1);
        wait_cyc(6180);

        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s[%0d] cycle %0d never sampled", sb[i].sig.name(), sb[i].bank, sb[i].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
